tx_ipg_inserter: RTL and testbench

Transmit-side IPG side-channel inserter for the 10G debug PHY. It sits on the 64b/66b TX path between the encoder output and the scrambler. It replaces the payload of all-idle control blocks with queued side-channel words, so the link partner's receive-side IPG extractor can recover them from the inter-packet gap. Non-idle blocks pass through untouched with fixed one-cycle latency.

---
 rtl/tx_ipg_inserter.sv | 106 ++++++++++
 tb/tb_tx_ipg_inserter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_ipg_inserter.sv
// Transmit-side IPG side-channel inserter: swaps the payload of all-idle 64b/66b
// control blocks for queued 48-bit side-channel words, one-cycle registered path.
module tx_ipg_inserter #(
    parameter int DATA_WIDTH = 64,
    parameter int HDR_WIDTH  = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  tx_clk,
    input  logic                  tx_rst,
    input  logic [DATA_WIDTH-1:0] enc_tx_data,
    input  logic [HDR_WIDTH-1:0]  enc_tx_hdr,
    output logic [DATA_WIDTH-1:0] out_tx_data,
    output logic [HDR_WIDTH-1:0]  out_tx_hdr,
    input  logic [47:0]           ipg_tx_data,
    input  logic                  ipg_tx_valid,
    output logic                  ipg_tx_ready,
    input  logic                  ipg_enable,
    output logic [5:0]            qspace,
    output logic [15:0]           ipg_tx_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]         DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [HDR_WIDTH-1:0]  HDR_CTRL   = HDR_WIDTH'(2'b01);
    localparam logic [7:0]            BT_IDLE    = 8'h1e;
    localparam logic [DATA_WIDTH-1:0] IDLE_BLOCK = {{(DATA_WIDTH-8){1'b0}}, BT_IDLE};

    logic [47:0]           r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_ready;
    logic [5:0]            r_qspace;
    logic [6:0]            r_seq;
    logic [15:0]           r_ins_count;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [HDR_WIDTH-1:0]  r_out_hdr;

    logic                  w_is_idle;
    logic                  w_insert;
    logic                  w_write;
    logic [CW-1:0]         w_count_next;
    logic [DATA_WIDTH-1:0] w_ins_block;

    // Side-channel handshake: a word transfers on any edge where ipg_tx_valid and
    // ipg_tx_ready are both high. Ready comes from registered occupancy only, so a
    // full queue refuses writes even on a cycle that also pops.
    assign w_write   = ipg_tx_valid && r_ready;
    assign w_is_idle = (enc_tx_hdr == HDR_CTRL) && (enc_tx_data == IDLE_BLOCK);
    assign w_insert  = w_is_idle && ipg_enable && (r_count != '0);

    // Tag MSB is always set so an inserted block can never look like a true idle.
    assign w_ins_block = {1'b1, r_seq, r_mem[r_rd_ptr], BT_IDLE};

    always_comb begin
        w_count_next = r_count;
        case ({w_write, w_insert})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge tx_clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= ipg_tx_data;
        end
    end

    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_ready     <= 1'b1;
            r_qspace    <= 6'(FIFO_DEPTH);
            r_seq       <= '0;
            r_ins_count <= '0;
            r_out_data  <= IDLE_BLOCK;
            r_out_hdr   <= HDR_CTRL;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_insert) begin
                r_rd_ptr    <= r_rd_ptr + AW'(1);
                r_seq       <= r_seq + 7'd1;
                r_ins_count <= r_ins_count + 16'd1;
                r_out_data  <= w_ins_block;
            end else begin
                r_out_data  <= enc_tx_data;
            end
            r_out_hdr <= enc_tx_hdr;
            r_count   <= w_count_next;
            r_ready   <= (w_count_next != DEPTH_C);
            r_qspace  <= 6'(FIFO_DEPTH) - 6'(w_count_next);
        end
    end

    assign out_tx_data  = r_out_data;
    assign out_tx_hdr   = r_out_hdr;
    assign ipg_tx_ready = r_ready;
    assign qspace       = r_qspace;
    assign ipg_tx_count = r_ins_count;

endmodule

// File: tb/tb_tx_ipg_inserter.sv
// Self-checking bench for tx_ipg_inserter: directed scenarios plus a random run,
// all checked against a queue-level behavioural model.
module tb_tx_ipg_inserter;
    localparam int          DEPTH = 16;
    localparam logic [63:0] IDLE  = 64'h1e;

    logic        tx_clk = 1'b0;
    logic        tx_rst = 1'b1;
    logic [63:0] enc_tx_data = '0;
    logic [1:0]  enc_tx_hdr = 2'b01;
    logic [63:0] out_tx_data;
    logic [1:0]  out_tx_hdr;
    logic [47:0] ipg_tx_data = '0;
    logic        ipg_tx_valid = 1'b0;
    logic        ipg_tx_ready;
    logic        ipg_enable = 1'b1;
    logic [5:0]  qspace;
    logic [15:0] ipg_tx_count;

    always #5 tx_clk = ~tx_clk;

    tx_ipg_inserter #(.DATA_WIDTH(64), .HDR_WIDTH(2), .FIFO_DEPTH(DEPTH)) dut (
        .tx_clk(tx_clk), .tx_rst(tx_rst),
        .enc_tx_data(enc_tx_data), .enc_tx_hdr(enc_tx_hdr),
        .out_tx_data(out_tx_data), .out_tx_hdr(out_tx_hdr),
        .ipg_tx_data(ipg_tx_data), .ipg_tx_valid(ipg_tx_valid), .ipg_tx_ready(ipg_tx_ready),
        .ipg_enable(ipg_enable), .qspace(qspace), .ipg_tx_count(ipg_tx_count)
    );

    // Behavioural model state: pending side-channel words, next tag, insert total.
    logic [47:0] exp_q[$];
    int          m_seq;
    int          m_ins;
    logic [63:0] exp_data;
    logic [1:0]  exp_hdr;
    logic [5:0]  exp_qspace;
    logic        exp_ready;
    logic [15:0] exp_count;
    bit          last_acc;
    bit          last_ins;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic drive(input logic [1:0] hdr, input logic [63:0] data, input logic en,
                         input logic vld, input logic [47:0] wd);
        logic [47:0] head;
        logic [6:0]  tag_seq;
        bit          acc;
        bit          ins;
        enc_tx_hdr = hdr; enc_tx_data = data; ipg_enable = en;
        ipg_tx_valid = vld; ipg_tx_data = wd;
        acc = vld && (exp_q.size() < DEPTH);
        ins = (hdr == 2'b01) && (data == IDLE) && en && (exp_q.size() != 0);
        exp_hdr = hdr;
        exp_data = data;
        if (ins) begin
            head = exp_q.pop_front();
            tag_seq = 7'(m_seq);
            exp_data = {1'b1, tag_seq, head, 8'h1e};
            m_seq = (m_seq + 1) % 128;
            m_ins++;
        end
        if (acc) exp_q.push_back(wd);
        last_acc = acc;
        last_ins = ins;
        exp_qspace = 6'(DEPTH - exp_q.size());
        exp_ready = (exp_q.size() < DEPTH);
        exp_count = 16'(m_ins);
        @(posedge tx_clk);
        #1;
    endtask

    task automatic do_reset();
        tx_rst = 1'b1;
        enc_tx_hdr = 2'b10;
        enc_tx_data = {$urandom(), $urandom()};
        ipg_tx_valid = 1'b1;
        ipg_tx_data = 48'hdead_beef_0001;
        ipg_enable = 1'b1;
        @(posedge tx_clk);
        #1;
        tx_rst = 1'b0;
        ipg_tx_valid = 1'b0;
        exp_q.delete();
        m_seq = 0;
        m_ins = 0;
        exp_data = IDLE; exp_hdr = 2'b01; exp_qspace = 6'(DEPTH);
        exp_ready = 1'b1; exp_count = '0;
    endtask

    task automatic rand_block(output logic [1:0] hdr, output logic [63:0] data);
        logic [55:0] codes;
        int          kind;
        kind = $urandom_range(0, 7);
        codes = {$urandom(), $urandom()};
        case (kind)
            0, 1, 2: begin hdr = 2'b01; data = IDLE; end
            3:       begin hdr = 2'b10; data = {$urandom(), $urandom()}; end
            4:       begin hdr = 2'b01; data = {codes, 8'h78}; end
            5:       begin hdr = 2'b01; data = {codes, 8'h87}; end
            6:       begin hdr = 2'b01; data = {56'h0, 8'h1e} | 64'h100; end
            default: begin
                hdr = 2'b01;
                for (int k = 0; k < 8; k++) codes[7*k +: 7] = 7'h06;
                data = {codes, 8'h1e};
            end
        endcase
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (out_tx_data !== 64'h1e) begin
            n_fail++; $display("FAIL reset_data: got %h want %h", out_tx_data, 64'h1e);
        end
        n_checks++;
        if (out_tx_hdr !== 2'b01) begin
            n_fail++; $display("FAIL reset_hdr: got %b want 01", out_tx_hdr);
        end
        n_checks++;
        if (qspace !== 6'd16) begin
            n_fail++; $display("FAIL reset_qspace: got %0d want 16", qspace);
        end
        n_checks++;
        if (ipg_tx_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b want 1", ipg_tx_ready);
        end
        n_checks++;
        if (ipg_tx_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d want 0", ipg_tx_count);
        end
    endtask

    task automatic test_passthrough();
        logic [1:0]  hdrs [4];
        logic [63:0] blks [4];
        do_reset();
        hdrs[0] = 2'b01; blks[0] = IDLE;
        hdrs[1] = 2'b01; blks[1] = {$urandom(), 24'($urandom()), 8'h78};
        hdrs[2] = 2'b10; blks[2] = {$urandom(), $urandom()};
        hdrs[3] = 2'b01; blks[3] = {$urandom(), 24'($urandom()), 8'h87};
        for (int i = 0; i < 8; i++) begin
            drive(hdrs[i % 4], blks[i % 4], 1'b1, 1'b0, '0);
            n_checks++;
            if (out_tx_data !== blks[i % 4] || out_tx_hdr !== hdrs[i % 4]) begin
                n_fail++;
                $display("FAIL passthrough[%0d]: got %b/%h want %b/%h", i, out_tx_hdr, out_tx_data,
                         hdrs[i % 4], blks[i % 4]);
            end
        end
    endtask

    task automatic test_single_insert();
        do_reset();
        drive(2'b10, 64'h0123_4567_89ab_cdef, 1'b1, 1'b1, 48'h00aabbccddee);
        drive(2'b01, IDLE, 1'b1, 1'b0, '0);
        n_checks++;
        if (out_tx_data !== 64'h80_00aabbccddee_1e || out_tx_hdr !== 2'b01) begin
            n_fail++; $display("FAIL single_insert: got %b/%h want 01/%h", out_tx_hdr, out_tx_data,
                               64'h80_00aabbccddee_1e);
        end
        drive(2'b01, IDLE, 1'b1, 1'b0, '0);
        n_checks++;
        if (out_tx_data !== IDLE) begin
            n_fail++; $display("FAIL single_next_idle: got %h want %h", out_tx_data, IDLE);
        end
        n_checks++;
        if (ipg_tx_count !== 16'd1) begin
            n_fail++; $display("FAIL single_count: got %0d want 1", ipg_tx_count);
        end
    endtask

    task automatic test_burst();
        logic [47:0] w;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            w = 48'h1111_1111_1111 * 48'(i + 1);
            drive(2'b10, {$urandom(), $urandom()}, 1'b1, 1'b1, w);
        end
        for (int i = 0; i < 10; i++) begin
            drive(2'b01, IDLE, 1'b1, 1'b0, '0);
            w = 48'h1111_1111_1111 * 48'(i + 1);
            n_checks++;
            if (i < 8 && out_tx_data !== {8'(8'h80 + i), w, 8'h1e}) begin
                n_fail++; $display("FAIL burst_insert[%0d]: got %h want %h", i, out_tx_data,
                                   {8'(8'h80 + i), w, 8'h1e});
            end else if (i >= 8 && out_tx_data !== IDLE) begin
                n_fail++; $display("FAIL burst_tail_idle[%0d]: got %h want %h", i, out_tx_data, IDLE);
            end
        end
        n_checks++;
        if (qspace !== 6'd16) begin
            n_fail++; $display("FAIL burst_qspace: got %0d want 16", qspace);
        end
    endtask

    task automatic test_backpressure();
        logic [47:0] first_w;
        first_w = {$urandom(), 16'($urandom())};
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(2'b10, {$urandom(), $urandom()}, 1'b1, 1'b1, (i == 0) ? first_w : 48'(i));
            n_checks++;
            if (ipg_tx_ready !== (i < 15) || qspace !== 6'(15 - i)) begin
                n_fail++; $display("FAIL bp_fill[%0d]: got ready=%b qspace=%0d want ready=%b qspace=%0d",
                                   i, ipg_tx_ready, qspace, (i < 15), 15 - i);
            end
        end
        drive(2'b10, {$urandom(), $urandom()}, 1'b1, 1'b1, 48'h1717_1717_1717);
        n_checks++;
        if (ipg_tx_ready !== 1'b0 || qspace !== 6'd0 || last_acc) begin
            n_fail++; $display("FAIL bp_17th: got ready=%b qspace=%0d want ready=0 qspace=0",
                               ipg_tx_ready, qspace);
        end
        drive(2'b01, IDLE, 1'b1, 1'b1, 48'h1717_1717_1717);
        n_checks++;
        if (ipg_tx_ready !== 1'b1 || qspace !== 6'd1) begin
            n_fail++; $display("FAIL bp_release: got ready=%b qspace=%0d want ready=1 qspace=1",
                               ipg_tx_ready, qspace);
        end
        n_checks++;
        if (out_tx_data !== {8'h80, first_w, 8'h1e}) begin
            n_fail++; $display("FAIL bp_insert: got %h want %h", out_tx_data, {8'h80, first_w, 8'h1e});
        end
    endtask

    task automatic test_nonidle_enable();
        logic [55:0] codes;
        logic [63:0] blk;
        do_reset();
        for (int i = 0; i < 4; i++) drive(2'b10, {$urandom(), $urandom()}, 1'b1, 1'b1, 48'(i + 100));
        for (int k = 0; k < 8; k++) codes[7*k +: 7] = 7'h06;
        for (int i = 0; i < 3; i++) begin
            blk = (i == 0) ? {codes, 8'h1e} : {$urandom(), $urandom()};
            drive((i == 0) ? 2'b01 : 2'b10, blk, 1'b1, 1'b0, '0);
            n_checks++;
            if (out_tx_data !== blk) begin
                n_fail++; $display("FAIL nonidle[%0d]: got %h want %h", i, out_tx_data, blk);
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(2'b01, IDLE, 1'b0, 1'b0, '0);
            n_checks++;
            if (out_tx_data !== IDLE || qspace !== 6'd12) begin
                n_fail++; $display("FAIL disabled[%0d]: got %h qspace=%0d want %h qspace=12",
                                   i, out_tx_data, qspace, IDLE);
            end
        end
        drive(2'b01, IDLE, 1'b1, 1'b0, '0);
        n_checks++;
        if (out_tx_data !== {8'h80, 48'd100, 8'h1e}) begin
            n_fail++; $display("FAIL reenable: got %h want %h", out_tx_data, {8'h80, 48'd100, 8'h1e});
        end
    endtask

    task automatic test_seq_wrap_reset();
        logic [7:0] want_tag;
        do_reset();
        for (int i = 0; i <= 130; i++) begin
            drive(2'b01, IDLE, 1'b1, (i < 130), 48'(i * 7 + 3));
            if (i > 0) begin
                want_tag = {1'b1, 7'((i - 1) % 128)};
                n_checks++;
                if (out_tx_data !== {want_tag, 48'((i - 1) * 7 + 3), 8'h1e}) begin
                    n_fail++; $display("FAIL wrap[%0d]: got %h want %h", i - 1, out_tx_data,
                                       {want_tag, 48'((i - 1) * 7 + 3), 8'h1e});
                end
            end
        end
        n_checks++;
        if (ipg_tx_count !== 16'd130) begin
            n_fail++; $display("FAIL wrap_count: got %0d want 130", ipg_tx_count);
        end
        for (int i = 0; i < 3; i++) drive(2'b10, {$urandom(), $urandom()}, 1'b1, 1'b1, 48'(i + 1));
        do_reset();
        n_checks++;
        if (out_tx_data !== IDLE || out_tx_hdr !== 2'b01 || qspace !== 6'd16) begin
            n_fail++; $display("FAIL midreset: got %b/%h qspace=%0d want 01/%h qspace=16",
                               out_tx_hdr, out_tx_data, qspace, IDLE);
        end
        drive(2'b10, {$urandom(), $urandom()}, 1'b1, 1'b1, 48'h0000_5555_aaaa);
        drive(2'b01, IDLE, 1'b1, 1'b0, '0);
        n_checks++;
        if (out_tx_data !== {8'h80, 48'h0000_5555_aaaa, 8'h1e}) begin
            n_fail++; $display("FAIL post_reset_tag: got %h want %h", out_tx_data,
                               {8'h80, 48'h0000_5555_aaaa, 8'h1e});
        end
    endtask

    task automatic test_random();
        logic [1:0]  hdr;
        logic [63:0] data;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rand_block(hdr, data);
            drive(hdr, data, ($urandom_range(0, 9) != 0), ($urandom_range(0, 2) != 0),
                  {$urandom(), 16'($urandom())});
            n_checks++;
            if (out_tx_data !== exp_data || out_tx_hdr !== exp_hdr || qspace !== exp_qspace ||
                ipg_tx_ready !== exp_ready || ipg_tx_count !== exp_count) begin
                n_fail++;
                $display("FAIL random[%0d]: got %b/%h q=%0d r=%b c=%0d want %b/%h q=%0d r=%b c=%0d",
                         i, out_tx_hdr, out_tx_data, qspace, ipg_tx_ready, ipg_tx_count,
                         exp_hdr, exp_data, exp_qspace, exp_ready, exp_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_single_insert();
        test_burst();
        test_backpressure();
        test_nonidle_enable();
        test_seq_wrap_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
